// File: rtl/multicycle_controller.sv
// Purpose : Moore sequencer stepping one MIPS-subset instruction (add/sub/lw/sw/beq[/j]) over several clocks.
// Latency : zero-wait CPI R-type 4, lw 5, sw 4, beq 3, j 3, illegal 2; each memory wait adds one clock.
// Backpressure: memory states hold on mem_ready=0, aborting to FETCH after MAX_WAIT+1 stalled clocks.
//
// Ports:
//   clk, reset (synchronous, active-high)       opcode/funct : IR fields, sampled in DECODE
//   mem_ready : memory completes this cycle     pc_write, pc_write_cond, pc_source, i_or_d,
//   mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
//   state : debug view of the FSM               illegal / mem_timeout : one-cycle pulses
// Optional feature: define MC_JUMP_EN to add the JUMP state (opcode 000010).
module multicycle_controller #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [3:0] state,
    output logic       illegal,
    output logic       mem_timeout
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BEQ      = 4'd8;
`ifdef MC_JUMP_EN
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [5:0] OP_J       = 6'b000010;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [3:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       is_lw_q, is_sub_q;
    logic       is_r, is_mem, is_beq, decode_ok;
    logic       waiting, timeout_hit;

    assign is_r   = (opcode == OP_RTYPE) && ((funct == F_ADD) || (funct == F_SUB));
    assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);

    always_comb begin
        decode_ok = is_r || is_mem || is_beq;
`ifdef MC_JUMP_EN
        if (opcode == OP_J) decode_ok = 1'b1;
`endif
    end

    // Only the three memory-handshake states can stall; the limit check must
    // lose to mem_ready arriving in the same cycle.
    assign waiting     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout_hit = waiting && !mem_ready && (wait_q == WAIT_LIM);

    // State register, wait counter and instruction-class latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_q   <= 8'd0;
            is_lw_q  <= 1'b0;
            is_sub_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) begin
                is_lw_q  <= (opcode == OP_LW);
                is_sub_q <= (funct == F_SUB);
            end
        end
    end

    // Next-state logic. The counter clears on every state change and on an
    // abort (FETCH re-entering FETCH), so each wait starts from zero.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_r)        state_d = S_R_EXEC;
                else if (is_mem) state_d = S_MEM_ADDR;
                else if (is_beq) state_d = S_BEQ;
`ifdef MC_JUMP_EN
                else if (opcode == OP_J) state_d = S_JUMP;
`endif
                else             state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : (timeout_hit ? S_FETCH : S_MEM_RD);
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        if (state_q == S_MEM_WR && !mem_ready && !timeout_hit) state_d = S_MEM_WR;

        if ((state_d != state_q) || timeout_hit) wait_d = 8'd0;
        else if (waiting && !mem_ready)          wait_d = wait_q + 8'd1;
        else                                     wait_d = wait_q;
    end

    // Output decode from the registered state; everything is held at zero in reset.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        state         = 4'd0;
        illegal       = 1'b0;
        mem_timeout   = 1'b0;
        if (!reset) begin
            state       = state_q;
            mem_timeout = timeout_hit;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    illegal   = !decode_ok;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = is_sub_q ? ALU_SUB : ALU_ADD;
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
`ifdef MC_JUMP_EN
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose : checks multicycle_controller cycle by cycle against an instruction-level trace model.
// Latency : one expected trace entry per clock; outputs sampled 1 ns after the falling edge.
// Backpressure: mem_ready stalls are scripted per instruction (wait count or abort).
module tb_multicycle_controller;

    localparam int MAXW = 3;
`ifdef MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal;
        logic       mem_timeout;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic [3:0] st;
        ctl_t       c;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, mem_timeout;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
    ctl_t       obs_c;

    int   total = 0;
    int   bad = 0;
    cyc_t exp_q[$];
    logic [5:0] cur_op, cur_fn;

    multicycle_controller #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .illegal(illegal), .mem_timeout(mem_timeout)
    );

    assign obs_c = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, mem_timeout};

    always #5 clk = ~clk;

    // ---------------- reference model: expected per-clock trace ----------------
    task automatic push(input logic [3:0] st, input logic rdy, input ctl_t c);
        cyc_t e;
        e.op = cur_op; e.fn = cur_fn; e.rdy = rdy; e.st = st; e.c = c;
        exp_q.push_back(e);
    endtask

    // A memory handshake: 'waits' not-ready clocks then a ready clock, or an
    // abort after MAXW+1 not-ready clocks when waits exceeds the limit.
    task automatic emit_wait(input logic [3:0] st, input ctl_t cw, input ctl_t cd,
                             input int waits, output bit aborted);
        ctl_t t;
        if (waits > MAXW) begin
            for (int k = 0; k <= MAXW; k++) begin
                t = cw;
                t.mem_timeout = (k == MAXW);
                push(st, 1'b0, t);
            end
            aborted = 1'b1;
        end else begin
            for (int k = 0; k < waits; k++) push(st, 1'b0, cw);
            push(st, 1'b1, cd);
            aborted = 1'b0;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        ctl_t c, cd;
        bit   ab;
        bit   is_r, is_ld, is_st, is_bq, is_j;
        cur_op = op; cur_fn = fn;
        is_r  = (op == 6'd0) && (fn == 6'd32 || fn == 6'd34);
        is_ld = (op == 6'd35);
        is_st = (op == 6'd43);
        is_bq = (op == 6'd4);
        is_j  = JUMP_EN && (op == 6'd2);
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        cd = c; cd.ir_write = 1'b1; cd.pc_write = 1'b1;
        emit_wait(4'd0, c, cd, fw, ab);
        if (ab) emit_wait(4'd0, c, cd, 0, ab);
        c = '0; c.alu_src_b = 2'b11;
        c.illegal = !(is_r || is_ld || is_st || is_bq || is_j);
        push(4'd1, 1'($urandom_range(0, 1)), c);
        if (is_r) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_op = (fn == 6'd34) ? 3'b001 : 3'b000;
            push(4'd6, 1'($urandom_range(0, 1)), c);
            c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1;
            push(4'd7, 1'($urandom_range(0, 1)), c);
        end else if (is_ld || is_st) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            push(4'd2, 1'($urandom_range(0, 1)), c);
            c = '0; c.i_or_d = 1'b1;
            if (is_ld) begin
                c.mem_read = 1'b1;
                emit_wait(4'd3, c, c, mw, ab);
                if (!ab) begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                    push(4'd4, 1'($urandom_range(0, 1)), c);
                end
            end else begin
                c.mem_write = 1'b1;
                emit_wait(4'd5, c, c, mw, ab);
            end
        end else if (is_bq) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            push(4'd8, 1'($urandom_range(0, 1)), c);
        end else if (is_j) begin
            c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10;
            push(4'd9, 1'($urandom_range(0, 1)), c);
        end
    endtask

    // Drive one clock's inputs, sample outputs mid-cycle, advance to next falling edge.
    task automatic drive_cycle(input logic rdy, output logic [3:0] os, output ctl_t oc);
        mem_ready = rdy;
        #1;
        os = state;
        oc = obs_c;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h3f; funct = 6'h3f;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state[%0d]: got %0d want 0", i, state); end
            total++; if (obs_c !== ctl_t'(0)) begin bad++; $display("FAIL reset_outputs[%0d]: got %h want 0", i, obs_c); end
        end
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL release_state: got %0d want 0", state); end
        total++; if (mem_read !== 1'b1 || alu_src_b !== 2'b01 || ir_write !== 1'b0)
            begin bad++; $display("FAIL release_fetch: got rd=%b srcb=%b irw=%b want 1 01 0", mem_read, alu_src_b, ir_write); end
    endtask

    task automatic test_r_type;
        cyc_t e; logic [3:0] os; ctl_t oc; int n = 0;
        run_instr(6'd0, 6'd32, 0, 0);
        run_instr(6'd0, 6'd34, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); opcode = e.op; funct = e.fn;
            drive_cycle(e.rdy, os, oc);
            total++; if (os !== e.st) begin bad++; $display("FAIL rtype_state[%0d]: got %0d want %0d", n, os, e.st); end
            total++; if (oc !== e.c) begin bad++; $display("FAIL rtype_ctl[%0d]: got %h want %h", n, oc, e.c); end
            n++;
        end
    endtask

    task automatic test_lw_wait;
        cyc_t e; logic [3:0] os; ctl_t oc; int n = 0;
        run_instr(6'd35, 6'($urandom), 0, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); opcode = e.op; funct = e.fn;
            drive_cycle(e.rdy, os, oc);
            total++; if (os !== e.st) begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", n, os, e.st); end
            total++; if (oc !== e.c) begin bad++; $display("FAIL lw_ctl[%0d]: got %h want %h", n, oc, e.c); end
            n++;
        end
    endtask

    task automatic test_sw_timeout;
        cyc_t e; logic [3:0] os; ctl_t oc; int n = 0;
        run_instr(6'd43, 6'($urandom), 0, MAXW + 1);
        run_instr(6'd0, 6'd32, MAXW + 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); opcode = e.op; funct = e.fn;
            drive_cycle(e.rdy, os, oc);
            total++; if (os !== e.st) begin bad++; $display("FAIL timeout_state[%0d]: got %0d want %0d", n, os, e.st); end
            total++; if (oc !== e.c) begin bad++; $display("FAIL timeout_ctl[%0d]: got %h want %h", n, oc, e.c); end
            n++;
        end
    endtask

    task automatic test_beq_illegal;
        cyc_t e; logic [3:0] os; ctl_t oc; int n = 0;
        run_instr(6'd4, 6'($urandom), 0, 0);
        run_instr(6'd63, 6'($urandom), 0, 0);
        run_instr(6'd0, 6'd0, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); opcode = e.op; funct = e.fn;
            drive_cycle(e.rdy, os, oc);
            total++; if (os !== e.st) begin bad++; $display("FAIL beq_ill_state[%0d]: got %0d want %0d", n, os, e.st); end
            total++; if (oc !== e.c) begin bad++; $display("FAIL beq_ill_ctl[%0d]: got %h want %h", n, oc, e.c); end
            n++;
        end
    endtask

    task automatic test_jump;
        cyc_t e; logic [3:0] os; ctl_t oc; int n = 0;
        run_instr(6'd2, 6'($urandom), 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); opcode = e.op; funct = e.fn;
            drive_cycle(e.rdy, os, oc);
            total++; if (os !== e.st) begin bad++; $display("FAIL jump_state[%0d]: got %0d want %0d", n, os, e.st); end
            total++; if (oc !== e.c) begin bad++; $display("FAIL jump_ctl[%0d]: got %h want %h", n, oc, e.c); end
            n++;
        end
    endtask

    task automatic test_reset_mid;
        cyc_t e; logic [3:0] os; ctl_t oc; int n = 0;
        ctl_t c;
        cur_op = 6'd35; cur_fn = 6'd0;
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1;
        push(4'd0, 1'b1, c);
        c = '0; c.alu_src_b = 2'b11;                push(4'd1, 1'b1, c);
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; push(4'd2, 1'b1, c);
        c = '0; c.mem_read = 1'b1; c.i_or_d = 1'b1; push(4'd3, 1'b0, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); opcode = e.op; funct = e.fn;
            drive_cycle(e.rdy, os, oc);
            total++; if (os !== e.st) begin bad++; $display("FAIL rstmid_state[%0d]: got %0d want %0d", n, os, e.st); end
            total++; if (oc !== e.c) begin bad++; $display("FAIL rstmid_ctl[%0d]: got %h want %h", n, oc, e.c); end
            n++;
        end
        // Reset lands while MEM_RD would otherwise complete.
        reset = 1'b1;
        drive_cycle(1'b1, os, oc);
        reset = 1'b0;
        total++; if (os !== 4'd0 || oc !== ctl_t'(0)) begin bad++; $display("FAIL rstmid_forced: got st=%0d ctl=%h want 0 0", os, oc); end
        run_instr(6'd0, 6'd34, 2, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); opcode = e.op; funct = e.fn;
            drive_cycle(e.rdy, os, oc);
            total++; if (os !== e.st) begin bad++; $display("FAIL rstmid_after_state[%0d]: got %0d want %0d", n, os, e.st); end
            total++; if (oc !== e.c) begin bad++; $display("FAIL rstmid_after_ctl[%0d]: got %h want %h", n, oc, e.c); end
            n++;
        end
    endtask

    task automatic test_random;
        cyc_t e; logic [3:0] os; ctl_t oc; int n = 0;
        logic [5:0] op, fn;
        int fw, mw;
        for (int i = 0; i < 40; i++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 8))
                0: begin op = 6'd0; fn = 6'd32; end
                1: begin op = 6'd0; fn = 6'd34; end
                2: op = 6'd0;
                3: op = 6'd35;
                4: op = 6'd43;
                5: op = 6'd4;
                6: op = 6'd2;
                7: op = 6'd63;
                default: op = 6'($urandom);
            endcase
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXW + 1)) : 0;
            mw = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, MAXW + 1)) : 0;
            run_instr(op, fn, fw, mw);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); opcode = e.op; funct = e.fn;
            drive_cycle(e.rdy, os, oc);
            total++; if (os !== e.st) begin bad++; $display("FAIL rand_state[%0d]: got %0d want %0d", n, os, e.st); end
            total++; if (oc !== e.c) begin bad++; $display("FAIL rand_ctl[%0d]: got %h want %h", n, oc, e.c); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_sw_timeout();
        test_beq_illegal();
        test_jump();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
